id_ex_pipe_stage: RTL

- Parametrised ID→EX pipeline register with valid/ready handshake, 2-entry skid buffer, synchronous flush and per-field payload.
- Carries operand A/B, shamt, rd, rt, sign-extended immediate and a decoded control word from decode to execute.
- Stall comes from EX back-pressure; there is no enable pin. Flush squashes in-flight beats on branch/exception.
- Sits between the decoder/register file and the ALU/forwarding stage.

---
 rtl/id_ex_pkg.sv | 50 +++++
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 rtl/id_ex_pipe_stage.sv | 61 ++++++
 3 files changed

// File: rtl/id_ex_pkg.sv
// Shared widths, control-word field layout and payload packing helpers
// for the ID->EX pipeline register.
package id_ex_pkg;

    // Default field widths for the reference 32-bit core
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_CTRL_W = 8;

    // Bit positions inside the opaque decoded-control word
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 3;
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_ALU_SRC    = 6;
    localparam int CTRL_SHIFT_SEL  = 7;

    // Payload layout at the default widths, most significant field first
    typedef struct packed {
        logic [DEF_DATA_W-1:0] dato_a;
        logic [DEF_DATA_W-1:0] dato_b;
        logic [DEF_REG_W-1:0]  shamt;
        logic [DEF_REG_W-1:0]  rd;
        logic [DEF_REG_W-1:0]  rt;
        logic [DEF_DATA_W-1:0] sign_ext_imm;
        logic [DEF_CTRL_W-1:0] ctrl;
    } id_ex_payload_t;

    localparam int PAYLOAD_W = $bits(id_ex_payload_t);

    // Width of the packed payload for arbitrary field widths
    function automatic int payload_width(input int data_w, input int reg_w, input int ctrl_w);
        return 3 * data_w + 3 * reg_w + ctrl_w;
    endfunction

    // Convenience accessors for consumers of the default-width control word
    function automatic logic [CTRL_ALU_OP_W-1:0] ctrl_alu_op(input logic [DEF_CTRL_W-1:0] c);
        return c[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W];
    endfunction

    function automatic logic ctrl_reg_write(input logic [DEF_CTRL_W-1:0] c);
        return c[CTRL_REG_WRITE];
    endfunction

    function automatic logic ctrl_mem_access(input logic [DEF_CTRL_W-1:0] c);
        return c[CTRL_MEM_READ] | c[CTRL_MEM_WRITE];
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register with an optional second (skid)
// entry so that in_ready can come straight from a flop.
module pipe_skid_reg #(
    parameter int WIDTH   = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             main_valid_q;
    logic             main_valid_d;
    logic [WIDTH-1:0] main_data_q;
    logic [WIDTH-1:0] main_data_d;
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;

    logic xfer_in;
    logic xfer_out;
    logic main_free;

    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = main_valid_q & out_ready;
    // Main entry can take a new beat this edge: empty, or its beat leaves now
    assign main_free = ~main_valid_q | xfer_out;

    // Main entry refills from the skid first so ordering stays FIFO
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
            end else if (xfer_in) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end
    end

    // Main entry state; payload is left untouched when the beat is squashed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic             skid_valid_d;
            logic [WIDTH-1:0] skid_data_d;

            // Skid catches a beat that arrives while the main entry is stuck
            always_comb begin
                skid_valid_d = skid_valid_q;
                skid_data_d  = skid_data_q;
                if (flush) begin
                    skid_valid_d = 1'b0;
                end else if (skid_valid_q && main_free) begin
                    skid_valid_d = 1'b0;
                end else if (xfer_in && !main_free) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                end
            end

            // Skid entry state
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_valid_q <= 1'b0;
                    skid_data_q  <= '0;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    skid_data_q  <= skid_data_d;
                end
            end

            // Ready depends only on a flop, breaking the ready path from EX
            assign in_ready = ~skid_valid_q;
        end else begin : g_no_skid
            assign skid_valid_q = 1'b0;
            assign skid_data_q  = '0;
            // Single entry: accept when empty or when the held beat leaves
            assign in_ready     = out_ready | ~main_valid_q;
        end
    endgenerate

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline stage: packs the decoded fields into one vector,
// registers it through the handshake buffer and unpacks it for EX.
module id_ex_pipe_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dato_a,
    input  logic [DATA_W-1:0] dato_b,
    input  logic [REG_W-1:0]  shamt,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rt,
    input  logic [DATA_W-1:0] sign_ext_imm,
    input  logic [CTRL_W-1:0] ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dato_a_out,
    output logic [DATA_W-1:0] dato_b_out,
    output logic [REG_W-1:0]  shamt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [DATA_W-1:0] sign_ext_imm_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [1:0]        occupancy
);

    localparam int PW = payload_width(DATA_W, REG_W, CTRL_W);

    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;

    // Field order matches id_ex_payload_t so the default build lines up with the struct
    assign in_payload = {dato_a, dato_b, shamt, rd, rt, sign_ext_imm, ctrl};

    pipe_skid_reg #(
        .WIDTH   (PW),
        .SKID_EN (SKID_EN)
    ) u_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload),
        .occupancy (occupancy)
    );

    assign {dato_a_out, dato_b_out, shamt_out, rd_out, rt_out, sign_ext_imm_out, ctrl_out} = out_payload;

endmodule
